double_buffer_ctrl: RTL and testbench



---
 rtl/double_buffer_ctrl_pkg.sv | 21 ++
 rtl/double_buffer_ctrl_skid.sv | 49 ++++
 rtl/double_buffer_ctrl.sv | 179 +++++++++++++++++
 tb/tb_double_buffer_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/double_buffer_ctrl_pkg.sv
// Shared types for the ping-pong buffer stream controller.
//   rd_state_t   : read-side FSM state encoding
//   skid_entry_t : one read-return skid entry {data, last}
// Skid entries are sized for the widest supported word (DBUF_MAX_DATA_WIDTH);
// narrower DATA_WIDTH builds zero-extend into the entry and slice back out.
package double_buffer_ctrl_pkg;

    localparam int DBUF_MAX_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_READ  = 2'd1,
        R_DRAIN = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic [DBUF_MAX_DATA_WIDTH-1:0] data;
        logic                           last;
    } skid_entry_t;

endpackage

// File: rtl/double_buffer_ctrl_skid.sv
// dbuf_skid: 2-entry FIFO catching read data returning from the buffer.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   push        : write push_entry this cycle
//   pop         : drop the head entry this cycle
//   push_entry  : entry to store
//   head        : oldest stored entry
//   count       : occupancy 0..2
// The caller guarantees no push when full without a simultaneous pop and no
// pop when empty.
module dbuf_skid
    import double_buffer_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  skid_entry_t push_entry,
    output skid_entry_t head,
    output logic [1:0]  count
);

    skid_entry_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // push and pop together leave the occupancy unchanged
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/double_buffer_ctrl.sv
// double_buffer_ctrl: stream-side controller for a ping-pong frame buffer.
// Writes FRAME_LEN-word frames from the input stream into the write bank,
// streams the completed frame out of the read bank, and requests a bank swap
// when the write bank is full and every read of the current frame is issued.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   in_valid/in_ready/in_data       : input word stream
//   out_valid/out_ready/out_data    : output word stream
//   out_last                        : marks the final word of each frame
//   buf_switch_banks                : one-cycle bank swap request
//   buf_wen/buf_wadr/buf_wdata      : buffer write port (0-cycle write)
//   buf_ren/buf_radr/buf_rdata      : buffer read port (rdata 1 cycle later)
// Optional build macro DBUF_CTRL_STATS_EN adds:
//   frame_count : 16-bit count of out_last handshakes (wraps)
//   in_stall    : sticky, set when in_valid is refused
//
// state   | meaning
// R_IDLE  | no frame held in the read bank
// R_READ  | issuing reads of the held frame
// R_DRAIN | all reads issued, skid / in-flight words may remain
module double_buffer_ctrl
    import double_buffer_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 7,
    parameter int FRAME_LEN       = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_last,
    output logic                       buf_switch_banks,
    output logic                       buf_wen,
    output logic [BANK_ADDR_WIDTH-1:0] buf_wadr,
    output logic [DATA_WIDTH-1:0]      buf_wdata,
    output logic                       buf_ren,
    output logic [BANK_ADDR_WIDTH-1:0] buf_radr,
    input  logic [DATA_WIDTH-1:0]      buf_rdata
`ifdef DBUF_CTRL_STATS_EN
    ,
    output logic [15:0]                frame_count,
    output logic                       in_stall
`endif
);

    localparam int               CNT_W    = BANK_ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    rd_state_t        state;
    rd_state_t        state_nxt;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] rcnt;
    logic             wr_full;
    logic             wr_hs;
    logic             swap;
    logic             issue;
    logic             issue_last;
    logic             inflight;
    logic             inflight_last;
    logic             pop;
    logic [1:0]       occ;
    skid_entry_t      skid_in;
    skid_entry_t      skid_head;

    // ---------------- write side ----------------
    assign in_ready  = rst_n & ~wr_full;
    assign wr_hs     = in_valid & in_ready;
    assign buf_wen   = wr_hs;
    assign buf_wadr  = rst_n ? wcnt[BANK_ADDR_WIDTH-1:0] : '0;
    assign buf_wdata = rst_n ? in_data : '0;

    // ---------------- read FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= R_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        swap       = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        if (rst_n) begin
            swap = wr_full & ((state == R_IDLE) | (state == R_DRAIN));
            // keep skid occupancy plus in-flight reads within the 2 skid slots
            issue = (state == R_READ) &&
                    (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
            issue_last = issue & (rcnt == LAST_IDX);
        end
        case (state)
            R_IDLE: begin
                if (swap) state_nxt = R_READ;
            end
            R_READ: begin
                if (issue_last) state_nxt = R_DRAIN;
            end
            R_DRAIN: begin
                if (swap) begin
                    state_nxt = R_READ;
                end else if ((occ == 2'd0) && !inflight) begin
                    state_nxt = R_IDLE;
                end
            end
            default: state_nxt = R_IDLE;
        endcase
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt          <= '0;
            rcnt          <= '0;
            wr_full       <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue_last;
            // swap needs wr_full, so it never coincides with a write handshake
            if (swap) begin
                wcnt    <= '0;
                rcnt    <= '0;
                wr_full <= 1'b0;
            end else begin
                if (wr_hs) begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == LAST_IDX) wr_full <= 1'b1;
                end
                if (issue) rcnt <= rcnt + 1'b1;
            end
        end
    end

    assign buf_switch_banks = swap;
    assign buf_ren          = issue;
    assign buf_radr         = rst_n ? rcnt[BANK_ADDR_WIDTH-1:0] : '0;

    // ---------------- read return skid ----------------
    assign skid_in.data = DBUF_MAX_DATA_WIDTH'(buf_rdata);
    assign skid_in.last = inflight_last;

    dbuf_skid u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight),
        .pop        (pop),
        .push_entry (skid_in),
        .head       (skid_head),
        .count      (occ)
    );

    assign out_valid = rst_n & (occ != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = rst_n ? skid_head.data[DATA_WIDTH-1:0] : '0;
    assign out_last  = out_valid & skid_head.last;

`ifdef DBUF_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count <= 16'd0;
            in_stall    <= 1'b0;
        end else begin
            if (pop && skid_head.last) frame_count <= frame_count + 16'd1;
            if (in_valid && !in_ready) in_stall <= 1'b1;
        end
    end
`else
    // statistics logic absent in this build
`endif

endmodule

// File: tb/tb_double_buffer_ctrl.sv
`timescale 1ns/1ps
module tb_double_buffer_ctrl;

    localparam int DW = 64;
    localparam int AW = 2;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          buf_switch_banks;
    logic          buf_wen;
    logic [AW-1:0] buf_wadr;
    logic [DW-1:0] buf_wdata;
    logic          buf_ren;
    logic [AW-1:0] buf_radr;
    logic [DW-1:0] buf_rdata;
`ifdef DBUF_CTRL_STATS_EN
    logic [15:0]   frame_count;
    logic          in_stall;
`endif

    always #5 clk = ~clk;

    double_buffer_ctrl #(
        .DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW), .FRAME_LEN(FL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .buf_switch_banks(buf_switch_banks),
        .buf_wen(buf_wen), .buf_wadr(buf_wadr), .buf_wdata(buf_wdata),
        .buf_ren(buf_ren), .buf_radr(buf_radr), .buf_rdata(buf_rdata)
`ifdef DBUF_CTRL_STATS_EN
        , .frame_count(frame_count), .in_stall(in_stall)
`endif
    );

    // Ping-pong memory: two banks, write bank flips on swap, reads hit the
    // other bank with one cycle of latency, reset returns to bank 0.
    logic [DW-1:0] mem [2][FL];
    logic          wbank;

    always @(posedge clk) begin
        if (!rst_n) begin
            wbank     <= 1'b0;
            buf_rdata <= '0;
        end else begin
            if (buf_wen) mem[wbank][buf_wadr] <= buf_wdata;
            if (buf_ren) buf_rdata <= mem[~wbank][buf_radr];
            if (buf_switch_banks) wbank <= ~wbank;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: accepted words must come out in acceptance order,
    // every FL-th output word carries last, a frame can be written only while
    // fewer than FL words sit in the write bank, and a swap is due exactly
    // when the write bank is full and all reads of the held frame are issued.
    logic [DW-1:0] exp_q[$];
    int            wr_words = 0;
    int            rd_issued = FL;
    int            outstanding = 0;
    int            out_idx = 0;
    int            swap_total = 0;
    logic          m_pop;
    logic          m_sw;
    logic [DW-1:0] m_exp;

    always begin
        @(negedge clk);
        #3;
        if (!rst_n) begin
            exp_q.delete();
            wr_words    = 0;
            rd_issued   = FL;
            outstanding = 0;
            out_idx     = 0;
        end else begin
            m_pop = out_valid & out_ready;
            m_sw  = (wr_words == FL) && (rd_issued == FL);
            check("in_ready", in_ready, wr_words < FL);
            check("swap", buf_switch_banks, m_sw);
            check("wen", buf_wen, in_valid & in_ready);
            if (buf_wen) check("wadr", buf_wadr, wr_words);
            if (buf_ren) begin
                check("ren_in_frame", rd_issued < FL, 1'b1);
                check("radr", buf_radr, rd_issued);
            end
            check("skid_bound", (outstanding + int'(buf_ren) - int'(m_pop)) <= 2, 1'b1);
            if (m_pop) begin
                check("out_pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    m_exp = exp_q.pop_front();
                    check("out_data", out_data, m_exp);
                    check("out_last", out_last, (out_idx % FL) == FL - 1);
                end
                out_idx++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                wr_words++;
            end
            if (buf_ren) rd_issued++;
            outstanding = outstanding + int'(buf_ren) - int'(m_pop);
            if (buf_switch_banks) begin
                wr_words  = 0;
                rd_issued = 0;
                swap_total++;
            end
        end
    end

    logic [DW-1:0] got_q[$];
    logic [DW-1:0] sent_q[$];
    logic          last_q[$];

    // Drives nwords input words and runs until npops output words are taken.
    // Optionally stalls out_ready for stall_len cycles once stall_after words
    // have been popped, and checks the held-off state on the final stall cycle.
    task automatic run_stream(input int nwords, input int base, input int npops,
                              input bit rnd, input int stall_after, input int stall_len);
        int            sent = 0;
        int            pops = 0;
        int            budget = 0;
        int            stall_cnt = 0;
        bit            stall_checked = 1'b0;
        logic [DW-1:0] cur;
        got_q.delete();
        sent_q.delete();
        last_q.delete();
        cur = rnd ? {$urandom, $urandom} : DW'(base);
        while (pops < npops && budget < 400) begin
            @(negedge clk);
            budget++;
            in_valid = (sent < nwords) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_data  = cur;
            if (pops >= stall_after && stall_cnt < stall_len) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            #4;
            if (stall_len > 0 && stall_cnt == stall_len && !stall_checked) begin
                stall_checked = 1'b1;
                check("bp_in_ready_low", in_ready, 1'b0);
                check("bp_ren_low", buf_ren, 1'b0);
                check("bp_out_held", out_valid, 1'b1);
            end
            if (in_valid && in_ready) begin
                sent_q.push_back(cur);
                sent++;
                cur = rnd ? {$urandom, $urandom} : cur + 1'b1;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                last_q.push_back(out_last);
                pops++;
            end
        end
        check("stream_pops", pops, npops);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    task automatic check_stream(input string tag, input int nexp);
        check({tag, "_count"}, got_q.size(), nexp);
        check({tag, "_sent"}, sent_q.size(), nexp);
        for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
            check({tag, "_data"}, got_q[i], sent_q[i]);
            check({tag, "_last"}, last_q[i], (i % FL) == FL - 1);
        end
    endtask

    int sw0;

    initial begin
        // reset: outputs quiet even with in_valid driven
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hDEAD_BEEF_0000_0001;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #4;
            check("rst_in_ready", in_ready, 1'b0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_last", out_last, 1'b0);
            check("rst_out_data", out_data, '0);
            check("rst_swap", buf_switch_banks, 1'b0);
            check("rst_wen", buf_wen, 1'b0);
            check("rst_wadr", buf_wadr, '0);
            check("rst_wdata", buf_wdata, '0);
            check("rst_ren", buf_ren, 1'b0);
            check("rst_radr", buf_radr, '0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #4;
        check("rel_in_ready", in_ready, 1'b1);
        check("rel_swap", buf_switch_banks, 1'b0);

        // single frame: swap one cycle after last write, data 3 cycles later
        for (int k = 1; k <= FL; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DW'(k);
            #4;
            check("t2_in_ready", in_ready, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #4;
        check("t2_swap", buf_switch_banks, 1'b1);
        @(negedge clk);
        #4;
        check("t2_ren", buf_ren, 1'b1);
        check("t2_no_out_e1", out_valid, 1'b0);
        check("t2_one_swap", buf_switch_banks, 1'b0);
        @(negedge clk);
        #4;
        check("t2_no_out_e2", out_valid, 1'b0);
        for (int k = 1; k <= FL; k++) begin
            @(negedge clk);
            #4;
            check("t2_out_valid", out_valid, 1'b1);
            check("t2_out_data", out_data, DW'(k));
            check("t2_out_last", out_last, k == FL);
        end
        @(negedge clk);
        #4;
        check("t2_out_done", out_valid, 1'b0);

        // streaming three frames, both sides always ready
        sw0 = swap_total;
        run_stream(3 * FL, 1, 3 * FL, 1'b0, 0, 0);
        check_stream("t3", 3 * FL);
        for (int i = 0; i < got_q.size(); i++) check("t3_value", got_q[i], DW'(i + 1));
        idle(1);
        check("t3_swaps", swap_total - sw0, 3);

        // backpressure: consumer stalls 10 cycles after two words
        idle(4);
        run_stream(4 * FL, 'h101, 4 * FL, 1'b0, 2, 10);
        check_stream("t4", 4 * FL);

        // reset mid-read: old frame must not reappear
        idle(4);
        run_stream(FL, 'h31, 2, 1'b0, 0, 0);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_stream(FL, 'hA, FL, 1'b0, 0, 0);
        check_stream("t5", FL);
        for (int i = 0; i < got_q.size(); i++) check("t5_value", got_q[i], DW'('hA + i));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #4;
            check("t5_no_stale", out_valid, 1'b0);
        end

        // randomized valid/ready and data
        run_stream(6 * FL, 0, 6 * FL, 1'b1, 0, 0);
        check_stream("t6", 6 * FL);

`ifdef DBUF_CTRL_STATS_EN
        idle(4);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        check("st_count_rst", frame_count, 16'd0);
        check("st_stall_rst", in_stall, 1'b0);
        // continuous in_valid is refused during each swap cycle
        run_stream(3 * FL, 'h201, 3 * FL, 1'b0, 0, 0);
        idle(2);
        check("st_frame_count", frame_count, 16'd3);
        check("st_in_stall", in_stall, 1'b1);
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
